// File: rtl/uart_rx2tx_relay_pkg.sv
// Shared definitions for the UART receive-to-transmit relay: frame timing
// defaults, relay FSM state encoding and the byte type.
package uart_rx2tx_relay_pkg;

    localparam int OVERSAMPLE       = 16;
    localparam int FRAME_BITS       = 11;
    localparam int FRAME_CYCLES_DEF = FRAME_BITS * OVERSAMPLE;
    localparam int FIFO_AW_DEF      = 4;
    localparam int WR_HIGH_DEF      = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } relay_state_e;

endpackage

// File: rtl/uart_rx2tx_relay_byte_fifo.sv
// Byte FIFO with a registered occupancy count.
// The read port is combinational from the head entry.
module uart_rx2tx_relay_byte_fifo
    import uart_rx2tx_relay_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  byte_t       i_din,
    input  logic        i_pop,
    output byte_t       o_dout,
    output logic [AW:0] o_fill,
    output logic        o_full,
    output logic        o_empty
);

    localparam int DEPTH = 1 << AW;

    byte_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_fill  = r_fill;
    assign o_full  = (r_fill == (AW + 1)'(DEPTH));
    assign o_empty = (r_fill == '0);

endmodule

// File: rtl/uart_rx2tx_relay.sv
// Buffers bytes from the UART receiver and replays them to the transmitter
// as start strobes spaced one full frame apart.
module uart_rx2tx_relay
    import uart_rx2tx_relay_pkg::*;
#(
    parameter int FIFO_AW      = FIFO_AW_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int WR_HIGH      = WR_HIGH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rdsig,
    input  byte_t            i_rx_data,
    input  logic             i_clr_ovf,
    output byte_t            o_tx_data,
    output logic             o_wrsig,
    output logic [FIFO_AW:0] o_fill,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int            CW          = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(WR_HIGH - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(FRAME_CYCLES - 3 - WR_HIGH);

    logic         r_rdsig_d;
    logic         r_overflow;
    relay_state_e r_state;
    logic [CW-1:0] r_cnt;
    logic         r_wrsig;
    byte_t        r_tx_data;

    logic         w_cap;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    byte_t        w_fifo_dout;

    assign w_cap  = i_rdsig & ~r_rdsig_d;
    assign w_push = w_cap & ~w_full;
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty;

    uart_rx2tx_relay_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (i_rx_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_fill  (o_fill),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // rdsig_d resets high so a flag already asserted at reset release is not an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdsig_d  <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_rdsig_d <= i_rdsig;
            if (w_cap & w_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // One pass IDLE->LOAD->STROBE->GAP->IDLE takes exactly FRAME_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wrsig   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_fifo_dout;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_wrsig <= 1'b1;
                    r_cnt   <= STROBE_LOAD;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_wrsig <= 1'b0;
                        r_cnt   <= GAP_LOAD;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_wrsig    = r_wrsig;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx2tx_relay.sv
// Self-checking bench for uart_rx2tx_relay: a queue/timeline model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_rx2tx_relay;

    localparam int F     = 176;
    localparam int WH    = 2;
    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rdsig   = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [7:0] o_tx_data;
    logic       o_wrsig;
    logic [4:0] o_fill;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;

    always #5 clk = ~clk;

    uart_rx2tx_relay #(
        .FIFO_AW      (4),
        .FRAME_CYCLES (F),
        .WR_HIGH      (WH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rdsig    (rdsig),
        .i_rx_data  (rx_data),
        .i_clr_ovf  (clr_ovf),
        .o_tx_data  (o_tx_data),
        .o_wrsig    (o_wrsig),
        .o_fill     (o_fill),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int t);
        if (cyc > t) check("schedule", cyc, t);
        while (cyc < t) tick();
        @(negedge clk);
    endtask

    // Model: byte queue plus the cycle from which the next pop may happen.
    logic [7:0] q[$];
    logic [7:0] m_tx;
    logic       m_wr;
    logic       m_ovf;
    logic       m_rdsig_d;
    logic       m_valid = 1'b0;
    int         idle_from;
    int         strobe_at;

    always @(negedge clk) begin
        logic was_full;
        logic cap;
        if (m_valid) begin
            check("tx_data", 32'(o_tx_data), 32'(m_tx));
            check("wrsig", 32'(o_wrsig), 32'(m_wr));
            check("fill", 32'(o_fill), q.size());
            check("empty", 32'(o_empty), 32'(q.size() == 0));
            check("full", 32'(o_full), 32'(q.size() == DEPTH));
            check("overflow", 32'(o_overflow), 32'(m_ovf));
        end
        if (rst) begin
            q.delete();
            m_tx      = 8'h00;
            m_ovf     = 1'b0;
            m_rdsig_d = 1'b1;
            idle_from = cyc + 1;
            strobe_at = -1000;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            was_full = (q.size() == DEPTH);
            cap      = rdsig && !m_rdsig_d;
            if (cyc >= idle_from && q.size() != 0) begin
                m_tx      = q.pop_front();
                strobe_at = cyc + 2;
                idle_from = cyc + F;
            end
            if (cap && !was_full) q.push_back(rx_data);
            if (cap && was_full) m_ovf = 1'b1;
            else if (clr_ovf)    m_ovf = 1'b0;
            m_rdsig_d = rdsig;
        end
        m_wr = (cyc + 1 >= strobe_at) && (cyc + 1 < strobe_at + WH);
    end

    // Log of wrsig rising edges as seen on the DUT pins.
    int         edge_cyc[$];
    logic [7:0] edge_dat[$];
    int         max_fill = 0;
    logic       prev_wr  = 1'b0;

    always @(negedge clk) begin
        if (o_wrsig === 1'b1 && prev_wr !== 1'b1) begin
            edge_cyc.push_back(cyc);
            edge_dat.push_back(o_tx_data);
        end
        prev_wr = o_wrsig;
        if (!$isunknown(o_fill) && int'(o_fill) > max_fill) max_fill = int'(o_fill);
    end

    task automatic clear_log();
        edge_cyc.delete();
        edge_dat.delete();
        max_fill = 0;
    endtask

    task automatic wait_edges(input string name, input int n, input int budget);
        int b = budget;
        while (edge_cyc.size() < n && b > 0) begin
            tick();
            b--;
        end
        check(name, edge_cyc.size(), n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_data", 32'(o_tx_data), 0);
        check("rst_wrsig", 32'(o_wrsig), 0);
        check("rst_fill", 32'(o_fill), 0);
        check("rst_empty", 32'(o_empty), 1);
        check("rst_full", 32'(o_full), 0);
        check("rst_overflow", 32'(o_overflow), 0);

        // Single byte: capture in cycle k, wrsig high k+3..k+4
        repeat (5) tick();
        clear_log();
        rx_data = 8'hA5;
        rdsig   = 1'b1;
        k       = cyc;
        at_neg(k + 1);
        check("t1_fill_one", 32'(o_fill), 1);
        at_neg(k + 2);
        check("t1_tx_setup", 32'(o_tx_data), 'hA5);
        check("t1_wr_setup", 32'(o_wrsig), 0);
        check("t1_fill_zero", 32'(o_fill), 0);
        tick();
        rdsig = 1'b0;
        at_neg(k + 3);
        check("t1_wr_hi0", 32'(o_wrsig), 1);
        at_neg(k + 4);
        check("t1_wr_hi1", 32'(o_wrsig), 1);
        at_neg(k + 5);
        check("t1_wr_lo", 32'(o_wrsig), 0);
        check("t1_tx_hold", 32'(o_tx_data), 'hA5);
        at_neg(k + 200);
        check("t1_edges", edge_cyc.size(), 1);
        if (edge_cyc.size() >= 1) check("t1_edge_cycle", edge_cyc[0], k + 3);
        check("t1_empty_end", 32'(o_empty), 1);

        // Burst of five bytes, 20 cycles apart
        tick();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'(i + 1);
            rdsig   = 1'b1;
            if (i == 0) k = cyc;
            tick();
            tick();
            rdsig = 1'b0;
            repeat (18) tick();
        end
        wait_edges("t2_edges_timeout", 5, 5 * F + 100);
        repeat (200) tick();
        @(negedge clk);
        check("t2_edge_count", edge_cyc.size(), 5);
        for (int i = 0; i < 5 && i < edge_cyc.size(); i++) begin
            check("t2_data", 32'(edge_dat[i]), i + 1);
            if (i > 0) check("t2_spacing", edge_cyc[i] - edge_cyc[i-1], 176);
        end
        check("t2_max_fill", max_fill, 4);
        check("t2_empty_end", 32'(o_empty), 1);

        // Overflow: 18 bytes 3 cycles apart, first one drains, 17th extra is dropped
        tick();
        clear_log();
        for (int i = 0; i < 18; i++) begin
            rx_data = 8'(8'h10 + i);
            rdsig   = 1'b1;
            if (i == 0) k = cyc;
            tick();
            rdsig = 1'b0;
            tick();
            tick();
        end
        @(negedge clk);
        check("t3_full", 32'(o_full), 1);
        check("t3_fill16", 32'(o_fill), 16);
        check("t3_ovf_set", 32'(o_overflow), 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("t3_ovf_clr", 32'(o_overflow), 0);
        // Drop and clear in the same cycle: set wins
        tick();
        rx_data = 8'h22;
        rdsig   = 1'b1;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        rdsig   = 1'b0;
        @(negedge clk);
        check("t3_set_wins", 32'(o_overflow), 1);
        check("t3_fill_still16", 32'(o_fill), 16);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        // Push while exactly full, coinciding with the second pop (cycle k+177)
        while (cyc < k + 177) tick();
        rx_data = 8'h23;
        rdsig   = 1'b1;
        tick();
        rdsig = 1'b0;
        @(negedge clk);
        check("t3_pop_push_fill", 32'(o_fill), 15);
        check("t3_pop_push_ovf", 32'(o_overflow), 1);
        check("t3_pop_push_full", 32'(o_full), 0);
        wait_edges("t3_edges_timeout", 17, 17 * F + 100);
        repeat (250) tick();
        @(negedge clk);
        check("t3_edge_count", edge_cyc.size(), 17);
        if (edge_cyc.size() >= 2) check("t3_second_edge", edge_cyc[1], k + 179);
        for (int i = 0; i < 17 && i < edge_cyc.size(); i++) begin
            check("t3_data", 32'(edge_dat[i]), 'h10 + i);
        end
        check("t3_empty_end", 32'(o_empty), 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // rdsig held high through reset release: no capture until a clean edge
        tick();
        rx_data = 8'h99;
        rdsig   = 1'b1;
        rst     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clear_log();
        repeat (10) tick();
        @(negedge clk);
        check("t4_held_fill", 32'(o_fill), 0);
        check("t4_held_empty", 32'(o_empty), 1);
        tick();
        rdsig = 1'b0;
        tick();
        rx_data = 8'h5C;
        rdsig   = 1'b1;
        tick();
        tick();
        rdsig = 1'b0;
        repeat (200) tick();
        @(negedge clk);
        check("t4_edge_count", edge_cyc.size(), 1);
        if (edge_cyc.size() >= 1) check("t4_data", 32'(edge_dat[0]), 'h5C);

        // Wrap-around: 40 bytes every 150 cycles
        tick();
        clear_log();
        for (int i = 0; i < 40; i++) begin
            rx_data = 8'(8'h40 + i);
            rdsig   = 1'b1;
            tick();
            rdsig = 1'b0;
            repeat (149) tick();
        end
        wait_edges("t5_edges_timeout", 40, 2000);
        @(negedge clk);
        check("t5_edge_count", edge_cyc.size(), 40);
        for (int i = 0; i < 40 && i < edge_cyc.size(); i++) begin
            check("t5_data", 32'(edge_dat[i]), 'h40 + i);
        end
        check("t5_no_overflow", 32'(o_overflow), 0);

        // Reset during the second strobe with three bytes buffered
        repeat (200) tick();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'(8'h70 + i);
            rdsig   = 1'b1;
            if (i == 0) k = cyc;
            tick();
            rdsig = 1'b0;
            tick();
            tick();
        end
        while (cyc < k + 179) tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_in_strobe", 32'(o_wrsig), 1);
        check("t6_buffered", 32'(o_fill), 3);
        check("t6_strobe_data", 32'(o_tx_data), 'h71);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_wr_cut", 32'(o_wrsig), 0);
        check("t6_fill_cleared", 32'(o_fill), 0);
        check("t6_tx_cleared", 32'(o_tx_data), 0);
        check("t6_empty", 32'(o_empty), 1);
        clear_log();
        repeat (400) tick();
        @(negedge clk);
        check("t6_no_strobes", edge_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx2tx_relay.md
Name: uart_rx2tx_relay

Overview:
- Sits directly downstream of the UART receiver and upstream of the UART transmitter, in the clk_uart domain (16x baud, 9600 baud -> 153.6 kHz).
- Captures each received byte on the rising edge of rdsig and buffers it in a small byte FIFO.
- Replays buffered bytes to the transmitter as rising-edge wrsig strobes, spaced so the transmitter never sees a new strobe mid-frame.
- Exposes fill level and overflow for the seven-segment display path.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.
- FRAME_CYCLES, 176, clk cycles between consecutive wrsig rising edges (11 bit-times x 16); must be >= WR_HIGH+3.
- WR_HIGH, 2, cycles wrsig is held high per strobe (>=1).

Ports:
- clk  in  1  clk_uart; sole clock.
- rst  in  1  synchronous, active-high reset.
- rdsig  in  1  receiver byte-complete flag; rising edge = new byte.
- rx_data  in  8  receiver data; valid when rdsig is high.
- clr_ovf  in  1  synchronous clear of overflow.
- tx_data  out  8  byte for transmitter datain.
- wrsig  out  1  transmitter start strobe.
- fill  out  FIFO_AW+1  bytes currently buffered (0..16).
- empty  out  1  fill==0.
- full  out  1  fill==2**FIFO_AW.
- overflow  out  1  sticky: byte dropped because FIFO full.

Behaviour:
- Reset values:
  - tx_data=8'h00, wrsig=0, fill=0, empty=1, full=0, overflow=0.
  - rd/wr pointers = 0; FSM = IDLE.
  - rdsig_d=1, so an rdsig held high through reset is not taken as an edge.
- Edge detect:
  - rdsig_d is rdsig registered every cycle.
  - cap = rdsig & ~rdsig_d.
  - When cap is high in cycle N, rx_data is sampled in cycle N.
- Write:
  - cap & ~full: mem[wr_ptr] <= rx_data; wr_ptr increments with natural wrap at 2**FIFO_AW.
  - cap & full: byte dropped, pointers unchanged, overflow <= 1.
  - overflow stays set until rst, or clr_ovf. If clr_ovf and a drop occur in the same cycle, overflow stays 1 (set wins).
- Read, via the FSM:
  - IDLE: if fill!=0, then tx_data <= mem[rd_ptr], rd_ptr++, go to LOAD. Otherwise stay.
  - LOAD: wrsig=0 for exactly 1 cycle (data setup before edge), then STROBE.
  - STROBE: wrsig=1 for WR_HIGH cycles, then GAP.
  - GAP: wrsig=0 for FRAME_CYCLES-2-WR_HIGH cycles, then IDLE.
  - tx_data is held stable from LOAD through the end of GAP.
  - Under backlog, consecutive wrsig rising edges are exactly FRAME_CYCLES apart.
- Latency: cap in cycle N -> fill increments at N+1 -> IDLE pops at N+1 -> LOAD at N+2 -> wrsig first high in cycle N+3 (when the FSM was idle and the FIFO empty).
- Occupancy:
  - fill = registered count.
  - Push and pop in the same cycle: fill unchanged.
  - Push into empty while the FSM is in GAP: byte waits, no strobe until GAP ends.
  - Pop is only issued when fill!=0, so there is no underflow path.
  - Pushing when exactly full is not possible even with a simultaneous pop. The push is evaluated against the pre-cycle full flag, so it is dropped, overflow is set, and the pop proceeds.
- rst mid-frame:
  - Everything returns to reset values immediately on the next edge.
  - Buffered bytes are discarded.
  - A strobe in progress is truncated (wrsig low next cycle).
- Width rules:
  - Pointers are FIFO_AW bits and wrap naturally.
  - fill is FIFO_AW+1 bits.
  - The GAP counter is $clog2(FRAME_CYCLES) bits and counts down to 0.

Decomposition:
- Shared header uart_defs:
  - FSM state encodings: IDLE=2'd0, LOAD=2'd1, STROBE=2'd2, GAP=2'd3.
  - Default FRAME_CYCLES and baud oversample factor (16).
- One sub-module, byte_fifo:
  - Parameter AW.
  - Ports: clk, rst, push, din, pop, dout, fill, full, empty.
  - Registered memory with sync reset of the pointers only.
- Top level holds the edge detect, the overflow flag and the FSM.

Test Plan:
- Single byte: reset, then rdsig 0->1 with rx_data=8'hA5 in cycle 10 -> wrsig high in cycles 13-14, tx_data=8'hA5 from cycle 12 through GAP, fill 1 then 0.
- Burst of 5 bytes (8'h01..8'h05, rdsig edges 20 cycles apart) -> five wrsig rising edges exactly 176 cycles apart, tx_data in order 01..05, fill peaks at 4, empty=1 at end.
- Overflow: 18 rdsig edges with no drain possible (first starts, FIFO fills to 16) -> full=1, overflow=1 after the drop, dropped bytes never transmitted; clr_ovf pulse -> overflow=0.
- Held rdsig: rdsig high through reset release, then held 10 cycles -> no capture, fill=0; next clean 0->1 edge -> exactly one capture.
- Wrap-around: push/pop 40 bytes with incrementing values at a steady rate -> pointers wrap twice, output sequence identical to input, no overflow.
- Reset mid-strobe: assert rst during STROBE with 3 bytes buffered -> next cycle wrsig=0, fill=0, tx_data=8'h00, no further strobes.
